mc_ctrl_fsm: RTL and testbench

//  Parametrised multi-cycle MIPS control FSM, successor to the current decoder. Sits beside the datapath.

---
 rtl/mc_pkg.sv | 72 +++++++
 rtl/mc_wait_timer.sv | 35 +++
 rtl/mc_ctrl_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: opcodes, state codes,
// ALU operation codes, control-word bit positions and trap cause codes.
// No logic; imported by mc_ctrl_fsm and mc_wait_timer.
package mc_pkg;

  // IR[31:26] opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12,
    S_JAL    = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  // ALUop encodings
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // Control word bit positions (multi-bit fields give their LSB)
  localparam int CTRL_W     = 20;
  localparam int C_PCWC     = 19;
  localparam int C_BRNE     = 18;
  localparam int C_PCW      = 17;
  localparam int C_IORD     = 16;
  localparam int C_MEMRD    = 15;
  localparam int C_MEMWR    = 14;
  localparam int C_M2R_LO   = 12;
  localparam int C_IRW      = 11;
  localparam int C_RDST_LO  = 9;
  localparam int C_REGW     = 8;
  localparam int C_PCSRC_LO = 6;
  localparam int C_ASRCA    = 5;
  localparam int C_ASRCB_LO = 3;
  localparam int C_ALUOP_LO = 0;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Opcodes that exist only in the extended instruction set
  function automatic logic is_ext_op(input logic [5:0] op);
    return (op == OP_BNE) || (op == OP_JAL) || (op == OP_SLTI) ||
           (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts cycles spent waiting on mem_ready, flags the cycle that reaches TIMEOUT.
// Latency: o_expired is combinational from the current count and i_en.
// Backpressure: none; i_clr has priority over i_en, holding i_en low freezes the count.
// Ports: clk, i_rst_n (async active-low), i_clr (sync clear), i_en (count this cycle),
//        o_expired (this increment reaches TIMEOUT).
module mc_wait_timer
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_cnt;

  // Count TIMEOUT-1 plus one more waiting cycle equals TIMEOUT.
  assign o_expired = i_en && (r_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: decodes IR opcode into a 20-bit control word per state, with traps.
// Latency: ctrl is Moore from state; PC/IR write strobes in FETCH are qualified by memory ready.
// Backpressure: mem_ready holds FETCH/MEMRD/MEMWR (bounded by TIMEOUT); stall freezes state and counter.
// Ports: clk, reset (async active-low), op[5:0], mem_ready, stall -> ctrl[19:0], state[3:0],
//        trap (one cycle in TRAP), trap_cause[1:0] (sticky until next trap), instr_done.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int EXT_OPS  = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic        mem_ready,
  input  logic        stall,
  output logic [19:0] ctrl,
  output logic [3:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic        instr_done
);

  localparam bit WAIT_EN = (MEM_WAIT != 0);
  localparam bit EXT_EN  = (EXT_OPS != 0);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_trap_cause;
  logic [1:0]  w_cause;
  logic        w_rdy;
  logic        w_wait_en;
  logic        w_expired;
  logic [CTRL_W-1:0] w_ctrl;
  logic        w_done;

  // Without wait support memory is always ready.
  assign w_rdy = mem_ready || !WAIT_EN;

  assign w_wait_en = WAIT_EN && !stall && !mem_ready &&
                     ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR));

  // Counter restarts whenever the state changes, so each wait phase gets a fresh budget.
  mc_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .i_rst_n   (reset),
    .i_clr     (w_next != r_state),
    .i_en      (w_wait_en),
    .o_expired (w_expired)
  );

  // Next-state logic; ready is checked before expiry so a late ready still completes.
  always_comb begin
    w_next = r_state;
    if (!stall) begin
      case (r_state)
        S_IDLE:   w_next = S_FETCH;
        S_FETCH:  if (w_rdy) w_next = S_DECODE;
                  else if (w_expired) w_next = S_TRAP;
        S_DECODE: begin
          case (op)
            OP_RTYPE:                            w_next = S_EXEC;
            OP_J:                                w_next = S_JUMP;
            OP_JAL:                              w_next = S_JAL;
            OP_BEQ, OP_BNE:                      w_next = S_BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:   w_next = S_IEXEC;
            OP_LW, OP_SW:                        w_next = S_MEMADR;
            default:                             w_next = S_TRAP;
          endcase
          if (!EXT_EN && is_ext_op(op)) w_next = S_TRAP;
        end
        S_MEMADR: w_next = op[3] ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (w_rdy) w_next = S_MEMWB;
                  else if (w_expired) w_next = S_TRAP;
        S_MEMWR:  if (w_rdy) w_next = S_FETCH;
                  else if (w_expired) w_next = S_TRAP;
        S_EXEC:   w_next = S_RWB;
        S_IEXEC:  w_next = S_IWB;
        S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB, S_JAL, S_TRAP:
                  w_next = S_FETCH;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Traps are entered only from DECODE (bad opcode) or a memory wait state (timeout).
  assign w_cause = (r_state == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_trap_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_next;
      if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
        r_trap_cause <= w_cause;
      end
    end
  end

  // Control word decode
  always_comb begin
    w_ctrl = '0;
    w_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ctrl[C_MEMRD]                   = 1'b1;
        w_ctrl[C_IRW]                     = w_rdy;
        w_ctrl[C_PCW]                     = w_rdy;
        w_ctrl[C_ASRCB_LO +: 2]           = 2'b01;
        w_ctrl[C_ALUOP_LO +: 3]           = ALU_ADD;
      end
      S_DECODE: begin
        w_ctrl[C_ASRCB_LO +: 2]           = 2'b11;
        w_ctrl[C_ALUOP_LO +: 3]           = ALU_ADD;
      end
      S_MEMADR: begin
        w_ctrl[C_ASRCA]                   = 1'b1;
        w_ctrl[C_ASRCB_LO +: 2]           = 2'b10;
        w_ctrl[C_ALUOP_LO +: 3]           = ALU_ADD;
      end
      S_MEMRD: begin
        w_ctrl[C_MEMRD]                   = 1'b1;
        w_ctrl[C_IORD]                    = 1'b1;
      end
      S_MEMWB: begin
        w_ctrl[C_REGW]                    = 1'b1;
        w_ctrl[C_M2R_LO +: 2]             = 2'b01;
        w_done                            = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl[C_MEMWR]                   = 1'b1;
        w_ctrl[C_IORD]                    = 1'b1;
        w_done                            = w_rdy;
      end
      S_EXEC: begin
        w_ctrl[C_ASRCA]                   = 1'b1;
        w_ctrl[C_ALUOP_LO +: 3]           = ALU_FUNCT;
      end
      S_RWB: begin
        w_ctrl[C_REGW]                    = 1'b1;
        w_ctrl[C_RDST_LO +: 2]            = 2'b01;
        w_done                            = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl[C_ASRCA]                   = 1'b1;
        w_ctrl[C_ALUOP_LO +: 3]           = ALU_SUB;
        w_ctrl[C_PCWC]                    = 1'b1;
        w_ctrl[C_BRNE]                    = op[0];
        w_ctrl[C_PCSRC_LO +: 2]           = 2'b01;
        w_done                            = 1'b1;
      end
      S_JUMP: begin
        w_ctrl[C_PCW]                     = 1'b1;
        w_ctrl[C_PCSRC_LO +: 2]           = 2'b10;
        w_done                            = 1'b1;
      end
      S_IEXEC: begin
        w_ctrl[C_ASRCA]                   = 1'b1;
        w_ctrl[C_ASRCB_LO +: 2]           = 2'b10;
        case (op)
          OP_SLTI: w_ctrl[C_ALUOP_LO +: 3] = ALU_SLT;
          OP_ANDI: w_ctrl[C_ALUOP_LO +: 3] = ALU_AND;
          OP_ORI:  w_ctrl[C_ALUOP_LO +: 3] = ALU_OR;
          default: w_ctrl[C_ALUOP_LO +: 3] = ALU_ADD;
        endcase
      end
      S_IWB: begin
        w_ctrl[C_REGW]                    = 1'b1;
        w_done                            = 1'b1;
      end
      S_JAL: begin
        w_ctrl[C_PCW]                     = 1'b1;
        w_ctrl[C_PCSRC_LO +: 2]           = 2'b10;
        w_ctrl[C_REGW]                    = 1'b1;
        w_ctrl[C_RDST_LO +: 2]            = 2'b10;
        w_ctrl[C_M2R_LO +: 2]             = 2'b10;
        w_done                            = 1'b1;
      end
      default: begin
        w_ctrl = '0;
        w_done = 1'b0;
      end
    endcase

    // A frozen cycle must not commit any architectural state.
    if (stall) begin
      w_ctrl[C_PCW]   = 1'b0;
      w_ctrl[C_PCWC]  = 1'b0;
      w_ctrl[C_IRW]   = 1'b0;
      w_ctrl[C_MEMWR] = 1'b0;
      w_ctrl[C_REGW]  = 1'b0;
      w_done          = 1'b0;
    end
  end

  assign ctrl       = w_ctrl;
  assign state      = r_state;
  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_trap_cause;
  assign instr_done = w_done;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm with two instances:
//   a: MEM_WAIT=0, EXT_OPS=1, TIMEOUT=15   b: MEM_WAIT=1, EXT_OPS=0, TIMEOUT=4
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst_a, rdy_a, stall_a;
  logic [5:0]  op_a;
  logic [19:0] ctrl_a;
  logic [3:0]  state_a;
  logic        trap_a, done_a;
  logic [1:0]  cause_a;

  logic        rst_b, rdy_b, stall_b;
  logic [5:0]  op_b;
  logic [19:0] ctrl_b;
  logic [3:0]  state_b;
  logic        trap_b, done_b;
  logic [1:0]  cause_b;

  mc_ctrl_fsm #(.MEM_WAIT(0), .EXT_OPS(1), .TIMEOUT(15)) u_dut_a (
    .clk(clk), .reset(rst_a), .op(op_a), .mem_ready(rdy_a), .stall(stall_a),
    .ctrl(ctrl_a), .state(state_a), .trap(trap_a), .trap_cause(cause_a), .instr_done(done_a)
  );

  mc_ctrl_fsm #(.MEM_WAIT(1), .EXT_OPS(0), .TIMEOUT(4)) u_dut_b (
    .clk(clk), .reset(rst_b), .op(op_b), .mem_ready(rdy_b), .stall(stall_b),
    .ctrl(ctrl_b), .state(state_b), .trap(trap_b), .trap_cause(cause_b), .instr_done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int st, input logic [19:0] ct,
                       input logic tr, input logic [1:0] ca, input logic dn);
    chk({tag, ".state"}, 32'(state_a), 32'(st));
    chk({tag, ".ctrl"},  32'(ctrl_a),  32'(ct));
    chk({tag, ".trap"},  32'(trap_a),  32'(tr));
    chk({tag, ".cause"}, 32'(cause_a), 32'(ca));
    chk({tag, ".done"},  32'(done_a),  32'(dn));
  endtask

  task automatic chk_b(input string tag, input int st, input logic [19:0] ct,
                       input logic tr, input logic [1:0] ca, input logic dn);
    chk({tag, ".state"}, 32'(state_b), 32'(st));
    chk({tag, ".ctrl"},  32'(ctrl_b),  32'(ct));
    chk({tag, ".trap"},  32'(trap_b),  32'(tr));
    chk({tag, ".cause"}, 32'(cause_b), 32'(ca));
    chk({tag, ".done"},  32'(done_b),  32'(dn));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0; op_a = 6'b000000; rdy_a = 1'b0; stall_a = 1'b0;
    rst_b = 1'b0; op_b = 6'b100011; rdy_b = 1'b1; stall_b = 1'b0;
    #2;

    // ---------------- instance a ----------------
    chk_a("a_rst", 0, 20'h0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("a_rst_hold", 0, 20'h0, 1'b0, 2'b00, 1'b0);
    end
    rst_a = 1'b1; #1;
    chk("a_idle.state", 32'(state_a), 32'd0);

    // add: FETCH DECODE EXEC RWB; mem_ready low is ignored with MEM_WAIT=0
    tick(); chk_a("a_add_fetch",  1, 20'h28808, 1'b0, 2'b00, 1'b0);
    tick(); chk_a("a_add_decode", 2, 20'h00018, 1'b0, 2'b00, 1'b0);
    tick(); chk_a("a_add_exec",   7, 20'h00022, 1'b0, 2'b00, 1'b0);
    tick(); chk_a("a_add_rwb",    8, 20'h00300, 1'b0, 2'b00, 1'b1);

    // illegal opcode
    tick(); op_a = 6'b111111; #1;
    chk_a("a_ill_fetch", 1, 20'h28808, 1'b0, 2'b00, 1'b0);
    tick(); chk_a("a_ill_decode", 2, 20'h00018, 1'b0, 2'b00, 1'b0);
    tick(); chk_a("a_ill_trap",  14, 20'h00000, 1'b1, 2'b01, 1'b0);
    tick(); op_a = 6'b000101; #1;
    chk_a("a_ill_after",  1, 20'h28808, 1'b0, 2'b01, 1'b0);

    // bne with a 2-cycle stall in BRANCH
    tick(); chk_a("a_bne_decode", 2, 20'h00018, 1'b0, 2'b01, 1'b0);
    tick(); stall_a = 1'b1; #1;
    chk_a("a_bne_stall0", 9, 20'h40061, 1'b0, 2'b01, 1'b0);
    tick(); chk_a("a_bne_stall1", 9, 20'h40061, 1'b0, 2'b01, 1'b0);
    tick(); stall_a = 1'b0; #1;
    chk_a("a_bne_go",     9, 20'hC0061, 1'b0, 2'b01, 1'b1);

    // jal
    tick(); op_a = 6'b000011; #1;
    chk_a("a_jal_fetch", 1, 20'h28808, 1'b0, 2'b01, 1'b0);
    tick(); chk_a("a_jal_decode", 2, 20'h00018, 1'b0, 2'b01, 1'b0);
    tick(); chk_a("a_jal",       13, 20'h22580, 1'b0, 2'b01, 1'b1);

    // reset in the middle of an instruction
    tick(); op_a = 6'b000000; #1;
    tick(); chk_a("a_mid_decode", 2, 20'h00018, 1'b0, 2'b01, 1'b0);
    rst_a = 1'b0; #1;
    chk_a("a_mid_reset",  0, 20'h00000, 1'b0, 2'b00, 1'b0);

    // ---------------- instance b ----------------
    rst_b = 1'b1; #1;
    chk("b_idle.state", 32'(state_b), 32'd0);

    // lw with memory holding off 3 cycles in MEMRD; ready arrives at count TIMEOUT-1
    tick(); chk_b("b_lw_fetch",  1, 20'h28808, 1'b0, 2'b00, 1'b0);
    tick(); chk_b("b_lw_decode", 2, 20'h00018, 1'b0, 2'b00, 1'b0);
    tick(); rdy_b = 1'b0; #1;
    chk_b("b_lw_memadr", 3, 20'h00030, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_b("b_lw_memrd_wait", 4, 20'h18000, 1'b0, 2'b00, 1'b0);
    end
    tick(); rdy_b = 1'b1; #1;
    chk_b("b_lw_memrd_rdy", 4, 20'h18000, 1'b0, 2'b00, 1'b0);
    tick(); chk_b("b_lw_memwb",  5, 20'h01100, 1'b0, 2'b00, 1'b1);

    // bne is illegal without the extended set
    tick(); op_b = 6'b000101; #1;
    chk_b("b_bne_fetch", 1, 20'h28808, 1'b0, 2'b00, 1'b0);
    tick(); chk_b("b_bne_decode", 2, 20'h00018, 1'b0, 2'b00, 1'b0);
    tick(); chk_b("b_bne_trap",  14, 20'h00000, 1'b1, 2'b01, 1'b0);

    // timeout in FETCH: four waiting cycles, then TRAP; PC/IR never written
    tick(); rdy_b = 1'b0; #1;
    chk_b("b_to_fetch0", 1, 20'h08008, 1'b0, 2'b01, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_b("b_to_fetch", 1, 20'h08008, 1'b0, 2'b01, 1'b0);
    end
    tick(); chk_b("b_to_trap", 14, 20'h00000, 1'b1, 2'b10, 1'b0);
    tick(); rdy_b = 1'b1; op_b = 6'b101011; #1;
    chk_b("b_to_after", 1, 20'h28808, 1'b0, 2'b10, 1'b0);

    // sw with one wait cycle in MEMWR
    tick(); chk_b("b_sw_decode", 2, 20'h00018, 1'b0, 2'b10, 1'b0);
    tick(); rdy_b = 1'b0; #1;
    chk_b("b_sw_memadr", 3, 20'h00030, 1'b0, 2'b10, 1'b0);
    tick(); chk_b("b_sw_memwr_wait", 6, 20'h14000, 1'b0, 2'b10, 1'b0);
    tick(); rdy_b = 1'b1; #1;
    chk_b("b_sw_memwr_rdy",  6, 20'h14000, 1'b0, 2'b10, 1'b1);
    tick(); chk_b("b_sw_next", 1, 20'h28808, 1'b0, 2'b10, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
